// File: rtl/bullet_collide.sv
// Bullet-versus-meteor collision stage: detects overlap, emits one hit per bullet
// flight, reports the lowest-index killed meteor and keeps a saturating BCD score.
module bullet_collide #(
  parameter int          NUM_METEORS    = 4,
  parameter int          POINTS_PER_HIT = 1,
  parameter logic [15:0] SCORE_MAX      = 16'h9999
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      bullet_active,
  input  logic [9:0]                bullet_X,
  input  logic [9:0]                bullet_Y,
  input  logic [9:0]                bullet_size,
  input  logic [10*NUM_METEORS-1:0] meteor_X,
  input  logic [10*NUM_METEORS-1:0] meteor_Y,
  input  logic [10*NUM_METEORS-1:0] meteor_size,
  input  logic [NUM_METEORS-1:0]    meteor_alive,
  output logic                      bullet_hit,
  output logic [NUM_METEORS-1:0]    meteor_kill,
  output logic [15:0]               score,
  output logic [7:0]                hit_count,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    HIT        = 2'd1,
    WAIT_CLEAR = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_METEORS-1:0]   overlap;
  logic [NUM_METEORS-1:0]   kill_d;
  logic                     hit_event;
  logic [15:0]              score_sum, score_next;
  logic [4:0]               digit_sum;
  logic [3:0]               carry;

  logic [10:0] bx, by, bs;
  assign bx = {1'b0, bullet_X};
  assign by = {1'b0, bullet_Y};
  assign bs = {1'b0, bullet_size};

  // 11-bit distances and limits so neither the difference nor the sum can wrap.
  for (genvar i = 0; i < NUM_METEORS; i++) begin : g_slot
    logic [10:0] mx, my, ms, dx, dy, lim;
    assign mx = {1'b0, meteor_X[10*i +: 10]};
    assign my = {1'b0, meteor_Y[10*i +: 10]};
    assign ms = {1'b0, meteor_size[10*i +: 10]};
    assign dx = (bx >= mx) ? (bx - mx) : (mx - bx);
    assign dy = (by >= my) ? (by - my) : (my - by);
    assign lim = bs + ms;
    assign overlap[i] = meteor_alive[i] & (dx < lim) & (dy < lim);
  end

  // Descending scan so the lowest overlapping index is the one left standing.
  always_comb begin
    kill_d = '0;
    for (int i = NUM_METEORS - 1; i >= 0; i--) begin
      if (overlap[i]) begin
        kill_d    = '0;
        kill_d[i] = 1'b1;
      end
    end
  end

  // Ripple BCD add; a carry out of the top digit or a result above the cap saturates.
  always_comb begin
    score_sum = '0;
    digit_sum = '0;
    carry     = 4'(POINTS_PER_HIT);
    for (int d = 0; d < 4; d++) begin
      digit_sum = {1'b0, score[4*d +: 4]} + {1'b0, carry};
      if (digit_sum > 5'd9) begin
        score_sum[4*d +: 4] = 4'(digit_sum - 5'd10);
        carry               = 4'd1;
      end else begin
        score_sum[4*d +: 4] = digit_sum[3:0];
        carry               = 4'd0;
      end
    end
    if ((carry != 4'd0) || (score_sum > SCORE_MAX)) score_next = SCORE_MAX;
    else                                            score_next = score_sum;
  end

  // bullet_hit is a one-cycle notification; the bullet stage acknowledges it by
  // dropping bullet_active, and WAIT_CLEAR waits for that drop before re-arming.
  always_comb begin
    state_d   = state_q;
    hit_event = 1'b0;
    case (state_q)
      ARMED: begin
        if (bullet_active && (|overlap)) begin
          hit_event = 1'b1;
          state_d   = HIT;
        end
      end
      HIT:        state_d = WAIT_CLEAR;
      WAIT_CLEAR: if (!bullet_active) state_d = ARMED;
      default:    state_d = ARMED;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ARMED;
      bullet_hit  <= 1'b0;
      meteor_kill <= '0;
      score       <= '0;
      hit_count   <= '0;
    end else begin
      state_q     <= state_d;
      bullet_hit  <= hit_event;
      meteor_kill <= hit_event ? kill_d : '0;
      if (hit_event) begin
        score     <= score_next;
        hit_count <= hit_count + 8'd1;
      end
    end
  end

  assign fsm_state = state_q;

endmodule
